// File: rtl/rob_retire_ctrl.sv
// Reorder buffer: dispatch allocates at tail in program order, writeback marks entries done,
// and up to RETIRE_W oldest contiguous done entries retire per cycle on registered lanes.
module rob_retire_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int DISP_W    = 2,
  parameter int RETIRE_W  = 2,
  parameter int NUM_WB    = 2,
  parameter int DATA_LEN  = 32,
  parameter int SRC_LEN   = 5,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DISP_W-1:0]            disp_v,
  input  logic [DISP_W*SRC_LEN-1:0]    disp_rd,
  input  logic [DISP_W-1:0]            disp_rf_wr,
  output logic                         disp_rdy,
  output logic [DISP_W*IDX_W-1:0]      disp_idx,
  input  logic [NUM_WB-1:0]            wb_v,
  input  logic [NUM_WB*IDX_W-1:0]      wb_idx,
  input  logic [NUM_WB*DATA_LEN-1:0]   wb_data,
  output logic [RETIRE_W-1:0]          ret_v,
  output logic [RETIRE_W-1:0]          ret_rf_wr,
  output logic [RETIRE_W*SRC_LEN-1:0]  ret_rd,
  output logic [RETIRE_W*DATA_LEN-1:0] ret_data,
  output logic [IDX_W:0]               rob_count,
  output logic                         rob_empty
);
  localparam logic [IDX_W:0]   LP_RDY_MAX = (IDX_W+1)'(ROB_DEPTH - DISP_W);
  localparam logic [IDX_W-1:0] LP_IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   LP_CNT_ONE = (IDX_W+1)'(1);

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_rfwr;
  logic [SRC_LEN-1:0]   r_rd   [ROB_DEPTH];
  logic [DATA_LEN-1:0]  r_data [ROB_DEPTH];
  logic [IDX_W-1:0]     r_head;
  logic [IDX_W-1:0]     r_tail;
  logic [IDX_W:0]       r_count;

  logic [IDX_W:0]       w_n_disp;
  logic [IDX_W:0]       w_n_ret;
  logic [IDX_W-1:0]     w_ofs;
  logic [RETIRE_W-1:0]  w_ret_sel;
  logic [IDX_W-1:0]     w_ret_idx [RETIRE_W];
  logic                 w_stop;
  logic [NUM_WB-1:0]    w_wb_take;
  logic                 w_wb_conflict;

  assign disp_rdy  = (r_count <= LP_RDY_MAX);
  assign rob_count = r_count;
  assign rob_empty = (r_count == '0);

  // Valid lanes are packed: each lane's index skips the idle lanes below it.
  always_comb begin
    w_n_disp = '0;
    w_ofs    = '0;
    disp_idx = '0;
    for (int unsigned k = 0; k < DISP_W; k++) begin
      disp_idx[k*IDX_W +: IDX_W] = r_tail + w_ofs;
      if (disp_v[k]) begin
        w_ofs    = w_ofs + LP_IDX_ONE;
        w_n_disp = w_n_disp + LP_CNT_ONE;
      end
    end
    if (!disp_rdy) w_n_disp = '0;
  end

  always_comb begin
    w_n_ret   = '0;
    w_ret_sel = '0;
    w_stop    = 1'b0;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      w_ret_idx[k] = r_head + IDX_W'(k);
      if (!w_stop && r_valid[w_ret_idx[k]] && r_done[w_ret_idx[k]]) begin
        w_ret_sel[k] = 1'b1;
        w_n_ret      = w_n_ret + LP_CNT_ONE;
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  // A port is suppressed when any lower-numbered port targets the same entry.
  always_comb begin
    w_wb_take     = '0;
    w_wb_conflict = 1'b0;
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      w_wb_take[p] = wb_v[p] && r_valid[wb_idx[p*IDX_W +: IDX_W]]
                     && !r_done[wb_idx[p*IDX_W +: IDX_W]];
      for (int unsigned q = 0; q < p; q++) begin
        if (wb_v[q] && wb_v[p] && (wb_idx[q*IDX_W +: IDX_W] == wb_idx[p*IDX_W +: IDX_W])) begin
          w_wb_take[p]  = 1'b0;
          w_wb_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
        if (w_ret_sel[k]) begin
          r_valid[w_ret_idx[k]] <= 1'b0;
          r_done[w_ret_idx[k]]  <= 1'b0;
        end
      end
      if (disp_rdy) begin
        for (int unsigned k = 0; k < DISP_W; k++) begin
          if (disp_v[k]) begin
            r_valid[disp_idx[k*IDX_W +: IDX_W]] <= 1'b1;
            r_done[disp_idx[k*IDX_W +: IDX_W]]  <= 1'b0;
          end
        end
      end
      for (int unsigned p = 0; p < NUM_WB; p++) begin
        if (w_wb_take[p]) r_done[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      r_head  <= r_head + w_n_ret[IDX_W-1:0];
      r_tail  <= r_tail + w_n_disp[IDX_W-1:0];
      r_count <= r_count + w_n_disp - w_n_ret;
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (disp_rdy) begin
      for (int unsigned k = 0; k < DISP_W; k++) begin
        if (disp_v[k]) begin
          r_rfwr[disp_idx[k*IDX_W +: IDX_W]] <= disp_rf_wr[k];
          r_rd[disp_idx[k*IDX_W +: IDX_W]]   <= disp_rd[k*SRC_LEN +: SRC_LEN];
        end
      end
    end
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      if (w_wb_take[p]) r_data[wb_idx[p*IDX_W +: IDX_W]] <= wb_data[p*DATA_LEN +: DATA_LEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_v     <= '0;
      ret_rf_wr <= '0;
      ret_rd    <= '0;
      ret_data  <= '0;
    end else if (flush) begin
      ret_v <= '0;
    end else begin
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
        if (w_ret_sel[k]) begin
          ret_v[k]                          <= 1'b1;
          ret_rf_wr[k]                      <= r_rfwr[w_ret_idx[k]];
          ret_rd[k*SRC_LEN +: SRC_LEN]      <= r_rd[w_ret_idx[k]];
          ret_data[k*DATA_LEN +: DATA_LEN]  <= r_data[w_ret_idx[k]];
        end else begin
          ret_v[k] <= 1'b0;
        end
      end
    end
  end

  a_wb_port_unique: assert property (@(posedge clk) disable iff (!rst_n) !w_wb_conflict);

endmodule
